// File: rtl/pocket_i2s_pkg.sv
// pocket_i2s_pkg: shared constants and the sample-to-slot transform for the Pocket I2S transmitter
package pocket_i2s_pkg;
    localparam int SLOT_BITS  = 32;
    localparam int FRAME_BITS = 64;
    localparam int FORMAT_I2S = 0;
    localparam int FORMAT_LJ  = 1;

    function automatic logic [SLOT_BITS-1:0] to_slot(
        input logic [SLOT_BITS-1:0] sample,
        input int                   bits,
        input logic                 is_signed
    );
        logic [SLOT_BITS-1:0] v;
        v = sample ^ (is_signed ? '0 : SLOT_BITS'(1) << (bits - 1));
        return v << (SLOT_BITS - bits);
    endfunction
endpackage

// File: rtl/pocket_audio_fifo.sv
// pocket_audio_fifo: synchronous FIFO with first-word-fall-through read and occupancy count
module pocket_audio_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                   iCLK,
    input  logic                   iRST_N,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_L = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;

    assign full    = level == DEPTH_L;
    assign empty   = level == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            level <= level + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge iCLK) if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/pocket_i2s_fifo_tx.sv
// pocket_i2s_fifo_tx: flow-controlled I2S/left-justified transmitter with fractional MCLK generation
module pocket_i2s_fifo_tx
    import pocket_i2s_pkg::*;
#(
    parameter int SAMPLE_BITS   = 16,
    parameter int STEREO        = 1,
    parameter int SIGNED        = 1,
    parameter int FORMAT        = FORMAT_I2S,
    parameter int FIFO_DEPTH    = 8,
    parameter int UNDERRUN_ZERO = 0,
    parameter int CLK_HZ        = 74250000,
    parameter int MCLK_HZ       = 12288000
) (
    input  logic                        iCLK,
    input  logic                        iRST_N,
    input  logic [SAMPLE_BITS-1:0]      iSAMPLE_L,
    input  logic [SAMPLE_BITS-1:0]      iSAMPLE_R,
    input  logic                        iVALID,
    output logic                        oREADY,
    output logic [$clog2(FIFO_DEPTH):0] oLEVEL,
    output logic                        oUNDERRUN,
    output logic                        oI2S_MCLK,
    output logic                        oI2S_SCLK,
    output logic                        oI2S_LRCK,
    output logic                        oI2S_DAT
);
    localparam logic [31:0] INC = 32'(2 * MCLK_HZ);
    localparam logic [31:0] THR = 32'(CLK_HZ);

    logic [31:0] acc;
    logic [1:0] div;
    logic [5:0] bcnt, bcnt_nxt;
    logic [FRAME_BITS-1:0] frame, last, fresh, nxt_frame;
    logic [SLOT_BITS-1:0] slot_l, slot_r;
    logic [2*SAMPLE_BITS-1:0] fifo_dout;
    logic ready_en, full, empty, mclk_tog, sclk_fall, load;

    assign mclk_tog  = acc >= THR;
    assign sclk_fall = mclk_tog && !oI2S_MCLK && div == 2'd3;
    assign load      = sclk_fall && bcnt == 6'd63;
    assign bcnt_nxt  = bcnt + 1'b1;
    assign oREADY    = ready_en && !full;
    assign oI2S_SCLK = div[1];

    pocket_audio_fifo #(
        .WIDTH(2 * SAMPLE_BITS),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .iCLK  (iCLK),
        .iRST_N(iRST_N),
        .push  (iVALID && oREADY),
        .pop   (load),
        .din   ({iSAMPLE_L, iSAMPLE_R}),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty),
        .level (oLEVEL)
    );

    assign slot_l = to_slot(SLOT_BITS'(fifo_dout[2*SAMPLE_BITS-1:SAMPLE_BITS]), SAMPLE_BITS, SIGNED != 0);
    assign slot_r = STEREO != 0 ? to_slot(SLOT_BITS'(fifo_dout[SAMPLE_BITS-1:0]), SAMPLE_BITS, SIGNED != 0) : slot_l;
    assign fresh = empty ? (UNDERRUN_ZERO != 0 ? '0 : last) : {slot_l, slot_r};
    assign nxt_frame = load ? fresh : frame << 1;

    // I2S takes DAT from the pre-shift MSB, giving the one-SCLK lag behind LRCK
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            acc       <= '0;
            div       <= '0;
            bcnt      <= '0;
            frame     <= '0;
            last      <= '0;
            ready_en  <= 1'b0;
            oUNDERRUN <= 1'b0;
            oI2S_MCLK <= 1'b0;
            oI2S_LRCK <= 1'b0;
            oI2S_DAT  <= 1'b0;
        end else begin
            ready_en  <= 1'b1;
            acc       <= mclk_tog ? acc + INC - THR : acc + INC;
            oUNDERRUN <= load && empty;
            if (mclk_tog) oI2S_MCLK <= !oI2S_MCLK;
            if (mclk_tog && !oI2S_MCLK) div <= div + 1'b1;
            if (sclk_fall) begin
                bcnt      <= bcnt_nxt;
                frame     <= nxt_frame;
                oI2S_LRCK <= bcnt_nxt[5];
                oI2S_DAT  <= FORMAT == FORMAT_LJ ? nxt_frame[FRAME_BITS-1] : frame[FRAME_BITS-1];
            end
            if (load && !empty) last <= fresh;
        end
    end
endmodule
